// File: rtl/gift_keysch_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gift_keysch_ctrl_if
//   Bundle between the GIFT-128 key-schedule sequencer, the key register
//   and the round datapath.
//   slave  : the sequencer side (gift_keysch_ctrl)
//   master : the environment side (register + round datapath)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface gift_keysch_ctrl_if;
  logic         inKeyLoaded;
  logic [127:0] inRegData;
  logic [5:0]   inRegRoundConst;
  logic         inRkReady;
  logic         outRegWr;
  logic [127:0] outRegData;
  logic [5:0]   outRegRoundConst;
  logic         outRkValid;
  logic [31:0]  outRkU;
  logic [31:0]  outRkV;
  logic [5:0]   outRc;
  logic         outBusy;
  logic         outDone;
  logic         outRcErr;

  modport slave (
    input  inKeyLoaded, inRegData, inRegRoundConst, inRkReady,
    output outRegWr, outRegData, outRegRoundConst, outRkValid,
           outRkU, outRkV, outRc, outBusy, outDone, outRcErr
  );

  modport master (
    output inKeyLoaded, inRegData, inRegRoundConst, inRkReady,
    input  outRegWr, outRegData, outRegRoundConst, outRkValid,
           outRkU, outRkV, outRc, outBusy, outDone, outRcErr
  );
endinterface
`default_nettype wire

// File: rtl/gift_keysch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gift_keysch_ctrl
//   Sequencer and update stage around the GIFT-128 key-schedule register.
//   Presents round key U/V and round constant over valid/ready, writes the
//   updated key/constant back on every accepted round, counts ROUNDS rounds
//   and pulses done afterwards.
//   Optional macro GIFT_KEYSCH_RC_CHECK_EN: shadow LFSR that flags a
//   mismatching round constant in the register (sticky outRcErr).
// Revision: 1.0
// ---------------------------------------------------------------------------
module gift_keysch_ctrl #(
  parameter int ROUNDS = 40,
  parameter int CNT_W  = 6
) (
  input  logic               inClk,
  input  logic               inRst,
  gift_keysch_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             in_run;
  logic             handshake;
  logic             wr_en;
  logic [15:0]      k0;
  logic [15:0]      k1;

  // One GIFT round-constant LFSR step: shift left, feedback c5 ^ c4 ^ 1.
  function automatic logic [5:0] rc_step(input logic [5:0] c);
    return {c[4:0], ~(c[5] ^ c[4])};
  endfunction

  assign in_run    = (state == S_RUN);
  assign handshake = in_run & bus.inRkReady;
  // A concurrent external load or reset must win over the internal write.
  assign wr_en     = handshake & ~bus.inKeyLoaded & ~inRst;

  assign k0 = bus.inRegData[15:0];
  assign k1 = bus.inRegData[31:16];

  assign bus.outRkU           = bus.inRegData[95:64];
  assign bus.outRkV           = bus.inRegData[31:0];
  assign bus.outRc            = bus.inRegRoundConst;
  assign bus.outRkValid       = in_run;
  assign bus.outBusy          = in_run;
  assign bus.outRegWr         = wr_en;
  assign bus.outRegData       = {k1[1:0], k1[15:2], k0[11:0], k0[15:12],
                                 bus.inRegData[127:32]};
  assign bus.outRegRoundConst = rc_step(bus.inRegRoundConst);
  // A pass cut short by a reload or reset never reports completion.
  assign bus.outDone          = (state == S_DONE) & ~bus.inKeyLoaded & ~inRst;

  // Round sequencer: load starts a pass, each handshake advances one round.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (bus.inKeyLoaded) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_IDLE;
        end
        S_RUN: begin
          if (handshake) begin
            if (cnt == LAST_CNT) begin
              state <= S_DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef GIFT_KEYSCH_RC_CHECK_EN
  logic [5:0] shadow_rc;
  logic       rc_err;

  // Shadow constant tracks the register; any divergence in RUN is sticky.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      shadow_rc <= 6'h01;
      rc_err    <= 1'b0;
    end else if (bus.inKeyLoaded) begin
      shadow_rc <= 6'h01;
      rc_err    <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_rc <= rc_step(shadow_rc);
      end
      if (in_run && (bus.inRegRoundConst != shadow_rc)) begin
        rc_err <= 1'b1;
      end
    end
  end

  assign bus.outRcErr = rc_err;
`else
  assign bus.outRcErr = 1'b0;
`endif

endmodule
`default_nettype wire
